// File: rtl/usb_tx_serializer_if.sv
// Byte handshake and encoder qualifiers between the packet source, the
// USB TX serializer and the downstream NRZI encoder.
interface usb_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_underrun;
    logic       tx_bit;
    logic       tx_eop;
    logic       tx_idle;

    modport master (
        output tx_data, tx_valid, tx_last,
        input  tx_ready, tx_busy, tx_underrun, tx_bit, tx_eop, tx_idle
    );

    modport slave (
        input  tx_data, tx_valid, tx_last,
        output tx_ready, tx_busy, tx_underrun, tx_bit, tx_eop, tx_idle
    );
endinterface

// File: rtl/usb_tx_serializer.sv
// USB TX serializer: SYNC prefix, LSB-first bytes with bit stuffing, then EOP.
// Define USB_TX_CRC16_EN to append the complemented CRC16 before EOP.
module usb_tx_serializer #(
    parameter int         CLKS_PER_BIT = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'h80
) (
    input  logic               clk,
    input  logic               rst,
    usb_tx_serializer_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

`ifdef USB_TX_CRC16_EN
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_EOP, S_EOP_J, S_CRC} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_STUFF, S_EOP, S_EOP_J} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bidx_q, bidx_d;
    logic [2:0]       ones_q, ones_d;
    logic [15:0]      sh_q, sh_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             last_seen_q, last_seen_d;
    logic             underrun_q, underrun_d;
    logic             xfer, wrap, cur_bit, data_step, do_end, h_full, h_last, bit_out;
    logic [7:0]       h_data;
    logic [2:0]       ones_nx;
    logic [4:0]       end_idx;
`ifdef USB_TX_CRC16_EN
    logic [15:0]      crc_q, crc_d;
    logic             in_crc_q, in_crc_d;
    assign end_idx = in_crc_q ? 5'd15 : 5'd7;
`else
    assign end_idx = 5'd7;
`endif

    assign xfer    = bus.tx_valid && bus.tx_ready;
    assign wrap    = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign cur_bit = sh_q[0];
    assign ones_nx = cur_bit ? ones_q + 3'd1 : 3'd0;
    // A byte arriving on the very edge of a byte boundary is used directly.
    assign h_full  = hold_full_q || xfer;
    assign h_data  = hold_full_q ? hold_q : bus.tx_data;
    assign h_last  = last_seen_q || (xfer && bus.tx_last);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bidx_d      = bidx_q;
        ones_d      = ones_q;
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        last_seen_d = last_seen_q;
        underrun_d  = 1'b0;
        data_step   = 1'b0;
        do_end      = 1'b0;
`ifdef USB_TX_CRC16_EN
        crc_d       = crc_q;
        in_crc_d    = in_crc_q;
`endif
        if (xfer) begin
            hold_d      = bus.tx_data;
            hold_full_d = 1'b1;
            if (bus.tx_last) last_seen_d = 1'b1;
        end
        if (state_q != S_IDLE) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: if (xfer) begin
                state_d = S_SYNC;
                sh_d    = {8'h00, SYNC_BYTE};
                bidx_d  = '0;
                cnt_d   = '0;
                ones_d  = '0;
`ifdef USB_TX_CRC16_EN
                crc_d    = 16'hFFFF;
                in_crc_d = 1'b0;
`endif
            end
            S_SYNC: if (wrap) begin
                ones_d = ones_nx;
                sh_d   = {1'b0, sh_q[15:1]};
                bidx_d = bidx_q + 5'd1;
                if (bidx_q == 5'd7) do_end = 1'b1;
            end
            S_DATA: data_step = 1'b1;
`ifdef USB_TX_CRC16_EN
            S_CRC:  data_step = 1'b1;
`endif
            S_STUFF: if (wrap) begin
                ones_d = '0;
                if (bidx_q == end_idx + 5'd1) do_end = 1'b1;
`ifdef USB_TX_CRC16_EN
                else state_d = in_crc_q ? S_CRC : S_DATA;
`else
                else state_d = S_DATA;
`endif
            end
            S_EOP: if (wrap) begin
                bidx_d = bidx_q + 5'd1;
                if (bidx_q == 5'd1) begin
                    state_d = S_EOP_J;
                    bidx_d  = '0;
                end
            end
            S_EOP_J: if (wrap) begin
                state_d     = S_IDLE;
                last_seen_d = 1'b0;
                hold_full_d = 1'b0;
                cnt_d       = '0;
            end
            default: state_d = S_IDLE;
        endcase

        if (data_step && wrap) begin
            ones_d = ones_nx;
            sh_d   = {1'b0, sh_q[15:1]};
            bidx_d = bidx_q + 5'd1;
`ifdef USB_TX_CRC16_EN
            // Reflected form of x^16+x^15+x^2+1, fed in transmit order.
            if (!in_crc_q)
                crc_d = {1'b0, crc_q[15:1]} ^ ((cur_bit ^ crc_q[0]) ? 16'hA001 : 16'h0000);
`endif
            if (ones_nx == 3'd6) state_d = S_STUFF;
            else if (bidx_q == end_idx) do_end = 1'b1;
        end

        if (do_end) begin
            bidx_d = '0;
`ifdef USB_TX_CRC16_EN
            if (in_crc_q) state_d = S_EOP;
            else
`endif
            if (h_full) begin
                sh_d        = {8'h00, h_data};
                hold_full_d = 1'b0;
                state_d     = S_DATA;
            end else if (h_last) begin
`ifdef USB_TX_CRC16_EN
                state_d  = S_CRC;
                sh_d     = ~crc_d;
                in_crc_d = 1'b1;
`else
                state_d  = S_EOP;
`endif
            end else begin
                underrun_d = 1'b1;
                state_d    = S_EOP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bidx_q      <= '0;
            ones_q      <= '0;
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            last_seen_q <= 1'b0;
            underrun_q  <= 1'b0;
`ifdef USB_TX_CRC16_EN
            crc_q       <= 16'hFFFF;
            in_crc_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bidx_q      <= bidx_d;
            ones_q      <= ones_d;
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            last_seen_q <= last_seen_d;
            underrun_q  <= underrun_d;
`ifdef USB_TX_CRC16_EN
            crc_q       <= crc_d;
            in_crc_q    <= in_crc_d;
`endif
        end
    end

    always_comb begin
        bit_out = 1'b1;
        case (state_q)
            S_SYNC, S_DATA:  bit_out = sh_q[0];
`ifdef USB_TX_CRC16_EN
            S_CRC:           bit_out = sh_q[0];
`endif
            S_STUFF, S_EOP:  bit_out = 1'b0;
            default:         bit_out = 1'b1;
        endcase
    end

    assign bus.tx_bit      = bit_out;
    assign bus.tx_eop      = (state_q == S_EOP);
    assign bus.tx_idle     = (state_q == S_IDLE) || (state_q == S_EOP_J);
    assign bus.tx_busy     = (state_q != S_IDLE);
    assign bus.tx_underrun = underrun_q;
    assign bus.tx_ready    = !hold_full_q && !last_seen_q &&
                             (state_q != S_EOP) && (state_q != S_EOP_J);
endmodule
